// File: rtl/gpu_shader_pkg.sv
// Shared types and helpers for the fragment shading path.
package gpu_shader_pkg;

  typedef enum logic [1:0] {
    REPLACE  = 2'd0,
    MODULATE = 2'd1,
    ADD      = 2'd2,
    DECAL    = 2'd3
  } blend_mode_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_VEC_SIZE   = 4;

  // Channel 0 sits in the least significant DATA_WIDTH bits.
  typedef logic [DEF_VEC_SIZE-1:0][DEF_DATA_WIDTH-1:0] color_vec_t;

  // Widest channel the saturate helper supports; wider operands are zero-extended into it.
  localparam int unsigned SAT_MAX_W = 64;
  localparam int unsigned SAT_IN_W  = 2 * SAT_MAX_W + 1;

  // True when val does not fit in width bits, i.e. the result must clamp to all-ones.
  function automatic logic needs_saturation(input logic [SAT_IN_W-1:0] val,
                                            input int unsigned         width);
    return (val >> width) != '0;
  endfunction

endpackage

// File: rtl/fs_blend_lane.sv
// One colour channel of the combiner: stage 1 forms the wide product/sum,
// stage 2 shifts, saturates and applies the channel mask.
module fs_blend_lane
  import gpu_shader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s1_en_i,
  input  logic                  s2_en_i,
  input  logic                  is_alpha_i,
  input  logic [DATA_WIDTH-1:0] frag_i,
  input  logic [DATA_WIDTH-1:0] texel_i,
  input  logic [DATA_WIDTH-1:0] texel_alpha_i,
  input  logic [1:0]            mode_i,
  input  logic                  mask_i,
  output logic [DATA_WIDTH-1:0] color_o
);

  localparam int unsigned AccW = 2 * DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] One = {{(DATA_WIDTH - 1){1'b0}}, 1'b1} << FRAC_BITS;

  logic [AccW-1:0]       acc_d, acc_q;
  logic [DATA_WIDTH-1:0] frag_q;
  blend_mode_e           mode_q;
  logic                  mask_q;

  logic [AccW-1:0]       frag_x, texel_x;
  logic [DATA_WIDTH-1:0] alpha_c;
  logic [AccW-1:0]       shifted;
  logic                  do_shift;
  logic [DATA_WIDTH-1:0] color_d;

  // Stage 1 arithmetic: widen operands and form the unshifted blend term.
  always_comb begin
    frag_x  = AccW'(frag_i);
    texel_x = AccW'(texel_i);
    alpha_c = (texel_alpha_i > One) ? One : texel_alpha_i;
    acc_d   = '0;
    case (blend_mode_e'(mode_i))
      REPLACE:  acc_d = texel_x;
      MODULATE: acc_d = frag_x * texel_x;
      ADD:      acc_d = frag_x + texel_x;
      DECAL: begin
        if (is_alpha_i) begin
          acc_d = frag_x;
        end else begin
          acc_d = frag_x * AccW'(One - alpha_c) + texel_x * AccW'(alpha_c);
        end
      end
      default: acc_d = '0;
    endcase
  end

  // Stage 1 registers, loaded on input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      frag_q <= '0;
      mode_q <= REPLACE;
      mask_q <= 1'b0;
    end else if (s1_en_i) begin
      acc_q  <= acc_d;
      frag_q <= frag_i;
      mode_q <= blend_mode_e'(mode_i);
      mask_q <= mask_i;
    end
  end

  // Stage 2 arithmetic: products come back to FRAC_BITS scale, sums and copies do not.
  always_comb begin
    do_shift = (mode_q == MODULATE) || ((mode_q == DECAL) && !is_alpha_i);
    shifted  = do_shift ? (acc_q >> FRAC_BITS) : acc_q;
    if (!mask_q) begin
      color_d = frag_q;
    end else if (needs_saturation(SAT_IN_W'(shifted), DATA_WIDTH)) begin
      color_d = '1;
    end else begin
      color_d = shifted[DATA_WIDTH-1:0];
    end
  end

  // Stage 2 output register; holds while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_o <= '0;
    end else if (s2_en_i) begin
      color_o <= color_d;
    end
  end

endmodule

// File: rtl/fragment_combiner.sv
// Two-stage valid/ready fragment colour combiner with per-channel mask and
// a retired-pixel counter.
module fragment_combiner
  import gpu_shader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned VEC_SIZE   = 4,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_frag_valid,
  output logic                           i_frag_ready,
  input  logic [VEC_SIZE*DATA_WIDTH-1:0] i_frag_color,
  input  logic [VEC_SIZE*DATA_WIDTH-1:0] i_texel_color,
  input  logic [1:0]                     i_mode,
  input  logic [VEC_SIZE-1:0]            i_chan_mask,
  output logic                           o_pixel_valid,
  input  logic                           o_pixel_ready,
  output logic [VEC_SIZE*DATA_WIDTH-1:0] o_pixel_color,
  output logic [CNT_WIDTH-1:0]           o_pixel_count
);

  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 s1_adv, s2_adv;
  logic                 in_hs, out_hs;
  logic                 s1_en, s2_en;

  // Handshake control: each stage advances when the one after it can take data.
  always_comb begin
    s2_adv     = !s2_valid_q || o_pixel_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_hs      = i_frag_valid && s1_adv;
    out_hs     = s2_valid_q && o_pixel_ready;
    s1_en      = in_hs;
    // Only overwrite the output register with real data so a drained pipe keeps its last colour.
    s2_en      = s2_adv && s1_valid_q;
    s1_valid_d = s1_adv ? i_frag_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    count_d    = out_hs ? count_q + CNT_WIDTH'(1) : count_q;
  end

  assign i_frag_ready  = s1_adv;
  assign o_pixel_valid = s2_valid_q;
  assign o_pixel_count = count_q;

  // Stage valid flags and retired-pixel counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      count_q    <= count_d;
    end
  end

  localparam int unsigned AlphaLsb = (VEC_SIZE - 1) * DATA_WIDTH;

  for (genvar g = 0; g < VEC_SIZE; g++) begin : gen_lane
    fs_blend_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .s1_en_i       (s1_en),
      .s2_en_i       (s2_en),
      .is_alpha_i    (g == VEC_SIZE - 1),
      .frag_i        (i_frag_color[g*DATA_WIDTH +: DATA_WIDTH]),
      .texel_i       (i_texel_color[g*DATA_WIDTH +: DATA_WIDTH]),
      .texel_alpha_i (i_texel_color[AlphaLsb +: DATA_WIDTH]),
      .mode_i        (i_mode),
      .mask_i        (i_chan_mask[g]),
      .color_o       (o_pixel_color[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_fragment_combiner.sv
// Scoreboard bench for fragment_combiner: the stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every output handshake.
module tb_fragment_combiner;
  import gpu_shader_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned VS = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned FW = DW * VS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_frag_valid;
  logic          i_frag_ready;
  logic [FW-1:0] i_frag_color;
  logic [FW-1:0] i_texel_color;
  logic [1:0]    i_mode;
  logic [VS-1:0] i_chan_mask;
  logic          o_pixel_valid;
  logic          o_pixel_ready;
  logic [FW-1:0] o_pixel_color;
  logic [CW-1:0] o_pixel_count;

  color_vec_t exp_q[$];
  color_vec_t mon_exp;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  fragment_combiner #(
    .DATA_WIDTH (DW),
    .VEC_SIZE   (VS),
    .FRAC_BITS  (16),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frag_valid  (i_frag_valid),
    .i_frag_ready  (i_frag_ready),
    .i_frag_color  (i_frag_color),
    .i_texel_color (i_texel_color),
    .i_mode        (i_mode),
    .i_chan_mask   (i_chan_mask),
    .o_pixel_valid (o_pixel_valid),
    .o_pixel_ready (o_pixel_ready),
    .o_pixel_color (o_pixel_color),
    .o_pixel_count (o_pixel_count)
  );

  function automatic color_vec_t vec(input logic [31:0] c3, input logic [31:0] c2,
                                     input logic [31:0] c1, input logic [31:0] c0);
    color_vec_t v;
    v[3] = c3; v[2] = c2; v[1] = c1; v[0] = c0;
    return v;
  endfunction

  function automatic color_vec_t splat(input logic [31:0] c);
    return vec(c, c, c, c);
  endfunction

  function automatic color_vec_t stream_tex(input int k);
    color_vec_t v;
    for (int c = 0; c < 4; c++) v[c] = 32'hA000_0000 + 32'(k) * 32'h100 + 32'(c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_pixel_valid && o_pixel_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pixel: got %h, required no output", o_pixel_color);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("pixel", o_pixel_color, mon_exp);
      end
    end
  end

  // Present one fragment until accepted; the result is queued when acceptance is seen.
  task automatic send(input color_vec_t frag, input color_vec_t tex, input logic [1:0] mode,
                      input logic [3:0] mask, input color_vec_t result);
    bit done = 1'b0;
    i_frag_valid  = 1'b1;
    i_frag_color  = frag;
    i_texel_color = tex;
    i_mode        = mode;
    i_chan_mask   = mask;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (i_frag_ready) begin
        exp_q.push_back(result);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i_frag_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got i_frag_ready stuck low, required acceptance");
    end
  endtask

  // Called right after a send: valid must be low next cycle and high the one after.
  task automatic check_latency(input string name);
    @(negedge clk);
    chk({name, "_valid_cycle1"}, FW'(o_pixel_valid), FW'(1'b0));
    @(negedge clk);
    chk({name, "_valid_cycle2"}, FW'(o_pixel_valid), FW'(1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_drained"}, FW'(exp_q.size()), FW'(0));
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b1;
    i_frag_valid  = 1'b0;
    i_frag_color  = '0;
    i_texel_color = '0;
    i_mode        = 2'd0;
    i_chan_mask   = '0;
    o_pixel_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", FW'(o_pixel_valid), FW'(1'b0));
    chk("rst_count", FW'(o_pixel_count), FW'(0));
    chk("rst_color", o_pixel_color, FW'(0));
    chk("rst_ready", FW'(i_frag_ready), FW'(1'b1));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic modulate and two-cycle latency.
    send(splat(32'h8000), splat(32'h8000), MODULATE, 4'b1111, splat(32'h4000));
    check_latency("modulate");

    // Saturation in MODULATE and ADD, back to back.
    send(splat(32'hFFFF_FFFF), splat(32'h0002_0000), MODULATE, 4'b1111, splat(32'hFFFF_FFFF));
    send(splat(32'h8000_0000), splat(32'h9000_0000), ADD, 4'b1111, splat(32'hFFFF_FFFF));

    // DECAL with partial alpha and with alpha clamped to ONE.
    send(vec(32'h1234, 32'h10000, 32'h10000, 32'h10000), vec(32'h4000, 0, 0, 0), DECAL,
         4'b1111, vec(32'h1234, 32'hC000, 32'hC000, 32'hC000));
    send(vec(32'h1234, 32'h10000, 32'h10000, 32'h10000), vec(32'h30000, 0, 0, 0), DECAL,
         4'b1111, vec(32'h1234, 0, 0, 0));

    // Channel mask in ADD and REPLACE.
    send(splat(32'h100), splat(32'h200), ADD, 4'b0101,
         vec(32'h100, 32'h300, 32'h100, 32'h300));
    send(vec(32'h44, 32'h33, 32'h22, 32'h11), vec(32'hDD, 32'hCC, 32'hBB, 32'hAA), REPLACE,
         4'b1010, vec(32'hDD, 32'h33, 32'hBB, 32'h11));
    drain("directed");

    // Backpressure: six fragments streamed, output stalled during cycles 3..6.
    pulse_reset();
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          send(splat(32'h0100_0000 * 32'(k)), stream_tex(k), REPLACE, 4'b1111, stream_tex(k));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 o_pixel_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          chk("stall_valid", FW'(o_pixel_valid), FW'(1'b1));
          chk("stall_color", o_pixel_color, stream_tex(1));
          chk("stall_full_ready", FW'(i_frag_ready), FW'(1'b0));
          @(posedge clk);
          #1;
        end
        o_pixel_ready = 1'b1;
      end
    join
    drain("stream");
    chk("stream_count", FW'(o_pixel_count), FW'(6));

    // Reset with both stages full.
    o_pixel_ready = 1'b0;
    send(splat(32'h1111_1111), splat(32'h2222_2222), REPLACE, 4'b1111, splat(32'h2222_2222));
    send(splat(32'h3333_3333), splat(32'h4444_4444), REPLACE, 4'b1111, splat(32'h4444_4444));
    chk("full_valid", FW'(o_pixel_valid), FW'(1'b1));
    chk("full_ready", FW'(i_frag_ready), FW'(1'b0));
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_valid", FW'(o_pixel_valid), FW'(1'b0));
    chk("midrst_count", FW'(o_pixel_count), FW'(0));
    chk("midrst_color", o_pixel_color, FW'(0));
    #2 rst_n = 1'b1;
    #1;
    chk("midrst_ready", FW'(i_frag_ready), FW'(1'b1));
    o_pixel_ready = 1'b1;
    @(posedge clk);
    #1;
    send(splat(32'h300), splat(32'h500), ADD, 4'b1111, splat(32'h800));
    check_latency("post_reset");
    drain("post_reset");
    chk("post_reset_count", FW'(o_pixel_count), FW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fragment_combiner.md
# fragment_combiner

Parametrised, pipelined texture/fragment colour combiner. It sits between the rasteriser/texture-fetch stage and the framebuffer write path. It is the successor to the single-mode, unstalled fragment shading stage. It adds selectable blend modes, fixed-point saturating arithmetic, a per-channel write mask, valid/ready backpressure through a two-stage pipeline, and a retired-pixel counter.

## Interface
- DATA_WIDTH, 32: bits per colour channel, unsigned fixed point.
- VEC_SIZE, 4: channels per colour; channel VEC_SIZE-1 is alpha (VEC_SIZE ≥ 2).
- FRAC_BITS, 16: fraction bits; ONE = 1 << FRAC_BITS (FRAC_BITS < DATA_WIDTH).
- CNT_WIDTH, 32: width of retired-pixel counter.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_frag_valid  in  1  fragment presented.
- i_frag_ready  out  1  combiner accepts fragment this cycle.
- i_frag_color  in  VEC_SIZE×DATA_WIDTH  interpolated fragment colour.
- i_texel_color  in  VEC_SIZE×DATA_WIDTH  texel colour for the same fragment.
- i_mode  in  2  blend mode, sampled with the fragment.
- i_chan_mask  in  VEC_SIZE  1 = channel takes blend result, 0 = channel passes i_frag_color.
- o_pixel_valid  out  1  result presented.
- o_pixel_ready  in  1  downstream accepts result.
- o_pixel_color  out  VEC_SIZE×DATA_WIDTH  combined colour.
- o_pixel_count  out  CNT_WIDTH  number of output handshakes since reset, wraps.

## Operation
- Modes:
  - REPLACE (0): out = texel.
  - MODULATE (1): out = sat((frag·texel) >> FRAC_BITS).
  - ADD (2): out = sat(frag + texel).
  - DECAL (3): a = min(texel[alpha], ONE). For non-alpha channels, out = sat((frag·(ONE−a) + texel·a) >> FRAC_BITS). The alpha channel is frag[alpha].
- sat() clamps to 2^DATA_WIDTH − 1. Products are 2·DATA_WIDTH bits; the DECAL sum is 2·DATA_WIDTH+1 bits. Truncate (no rounding) on shift.
- The mask is applied in stage 2. Masked-off channels output frag unchanged in every mode.
- Stage 1 registers products or sums, frag, mode and mask on input handshake (i_frag_valid & i_frag_ready).
- Stage 2 registers shift/saturate/mask result into o_pixel_color.
- o_pixel_count increments on o_pixel_valid & o_pixel_ready, and wraps to 0 after 2^CNT_WIDTH − 1.

## Timing
- Latency: 2 cycles from input handshake to o_pixel_valid when unstalled. Throughput is 1 fragment/cycle.
- Per-stage control:
  - s2_adv = !s2_valid | o_pixel_ready.
  - s1_adv = !s1_valid | s2_adv.
  - i_frag_ready = s1_adv. This is combinational from o_pixel_ready; there is no combinational path from i_frag_valid to i_frag_ready.
- Bubbles collapse: an empty stage fills even while stage 2 is stalled.
- While o_pixel_valid & !o_pixel_ready, o_pixel_color and o_pixel_valid hold stable.
- Full: both stages valid and o_pixel_ready low → i_frag_ready low. Simultaneous output handshake and input handshake in a full pipe shifts both stages with no loss.
- Reset, asynchronous at any time including mid-stream:
  - Stage valids, o_pixel_valid and o_pixel_count = 0; o_pixel_color = 0; all stage data = 0.
  - i_frag_ready = 1 while reset is released.
  - In-flight fragments are discarded.
- Ordering is strictly FIFO.

## Structure
- Shared package gpu_shader_pkg holds:
  - blend_mode_e enum (REPLACE, MODULATE, ADD, DECAL).
  - Colour vector typedef parametrised by DATA_WIDTH/VEC_SIZE.
  - Saturate helper function.
- Sub-module fs_blend_lane: one channel, stage-1 and stage-2 datapath with enable inputs, instantiated VEC_SIZE times. The alpha lane gets an is_alpha tie-off.
- Handshake control and the counter live in the top level.

## Test plan
- MODULATE, frag = texel = 0x8000 on all channels, mask 4'b1111 → o_pixel_color all 0x4000, o_pixel_valid exactly 2 cycles after handshake.
- MODULATE saturate: frag 0xFFFF_FFFF, texel 0x0002_0000 → 0xFFFF_FFFF. ADD with 0x8000_0000 + 0x9000_0000 → 0xFFFF_FFFF.
- DECAL: frag rgb 0x10000, alpha 0x1234; texel rgb 0, alpha 0x4000 → rgb 0xC000, alpha 0x1234. Texel alpha 0x30000 behaves as 0x10000 → rgb 0.
- Mask: ADD, frag 0x100, texel 0x200, mask 4'b0101 → channels 0,2 = 0x300; channels 1,3 = 0x100.
- Backpressure: stream 6 back-to-back fragments with distinct colours, o_pixel_ready low for cycles 3–6 → output stable while stalled, i_frag_ready low once both stages are full, all 6 delivered in order with none duplicated, o_pixel_count = 6.
- Reset mid-stream with both stages valid → o_pixel_valid and o_pixel_count drop to 0 immediately. After release, a new fragment appears 2 cycles after its handshake with the correct value.
